oled_textterm: RTL



---
 rtl/oled_textterm_pkg.sv | 18 +
 rtl/ram_2port.sv | 27 ++
 rtl/oled_textterm.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/oled_textterm_pkg.sv
// Shared types and control codes for the OLED text terminal.
// State encoding plus the character codes the terminal interprets.
package oled_textterm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ROW,
    CLEAR_ALL
  } state_t;

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_LAST  = 8'h7E;

endpackage

// File: rtl/ram_2port.sv
// Simple dual-port RAM: port 1 writes, port 2 is a registered read.
// The read register clears on reset so the output starts at zero.
module ram_2port #(
  parameter int ADDR_BITS = 7,
  parameter int WORD_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [WORD_BITS-1:0] i_wr_data,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [WORD_BITS-1:0] o_rd_data
);

  logic [WORD_BITS-1:0] r_mem [2**ADDR_BITS];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_rd_data <= '0;
    else       o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/oled_textterm.sv
// Scrolling text terminal feeding the serial OLED font path.
// Optional blinking cursor: define OLED_TEXTTERM_CURSOR_EN.
module oled_textterm
  import oled_textterm_pkg::*;
#(
  parameter int SCREEN_WIDTH        = 128,
  parameter int SCREEN_HEIGHT       = 64,
  parameter int TILE_WIDTH          = 8,
  parameter int CURSOR_BLINK_CYCLES = 13_500_000,
  localparam int COLS      = SCREEN_WIDTH / TILE_WIDTH,
  localparam int ROWS      = SCREEN_HEIGHT / 8,
  localparam int HCTR_BITS = $clog2(SCREEN_WIDTH),
  localparam int PAGE_BITS = $clog2(ROWS),
  localparam int COL_BITS  = $clog2(COLS),
  localparam int TW_BITS   = $clog2(TILE_WIDTH)
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_char_valid,
  input  logic [7:0]           in_char,
  output logic                 out_char_ready,
  input  logic [HCTR_BITS-1:0] in_hpix,
  input  logic [PAGE_BITS-1:0] in_vpage,
  output logic [6:0]           out_font_char,
  output logic [TW_BITS-1:0]   out_font_col,
  input  logic [7:0]           in_font_line,
  output logic [7:0]           out_pixels,
  output logic [COL_BITS-1:0]  out_cursor_x,
  output logic [PAGE_BITS-1:0] out_cursor_y,
  output logic                 out_busy
);

  localparam int ADDR_BITS = PAGE_BITS + COL_BITS;
  localparam int CELLS     = ROWS * COLS;

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_cnt;
  logic [COL_BITS-1:0]  r_x;
  logic [PAGE_BITS-1:0] r_y;
  logic [PAGE_BITS-1:0] r_off;
  logic [PAGE_BITS-1:0] r_clr_row;

  logic                 w_accept;
  logic                 w_print;
  logic                 w_last_col;
  logic                 w_lf;
  logic [PAGE_BITS-1:0] w_phys_y;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_waddr;
  logic [7:0]           w_wdata;
  logic [PAGE_BITS-1:0] w_rd_row;
  logic [COL_BITS-1:0]  w_rd_col;
  logic [ADDR_BITS-1:0] w_rd_addr;
  logic [7:0]           w_rd_data;
  logic                 w_unused;

  assign w_accept   = in_char_valid && (r_state == IDLE);
  assign w_print    = (in_char >= CHR_SPACE) && (in_char <= CHR_LAST);
  assign w_last_col = (r_x == '1);
  assign w_lf       = w_accept &&
                      ((in_char == CHR_LF) || (w_print && w_last_col));
  assign w_phys_y   = r_y + r_off;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = {w_phys_y, r_x};
    w_wdata = CHR_SPACE;
    unique case (r_state)
      CLEAR_ALL: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
      end
      CLEAR_ROW: begin
        w_we    = 1'b1;
        w_waddr = {r_clr_row, r_cnt[COL_BITS-1:0]};
      end
      default: begin
        if (w_accept && w_print) begin
          w_we    = 1'b1;
          w_wdata = in_char;
        end else if (w_accept && in_char == CHR_BS && r_x != '0) begin
          w_we    = 1'b1;
          w_waddr = {w_phys_y, r_x - COL_BITS'(1)};
        end
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state   <= CLEAR_ALL;
      r_cnt     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_off     <= '0;
      r_clr_row <= '0;
    end else begin
      unique case (r_state)
        CLEAR_ALL: begin
          r_cnt <= r_cnt + ADDR_BITS'(1);
          if (r_cnt == ADDR_BITS'(CELLS - 1)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_off   <= '0;
          end
        end
        CLEAR_ROW: begin
          r_cnt <= r_cnt + ADDR_BITS'(1);
          if (r_cnt[COL_BITS-1:0] == '1) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (w_accept) begin
            if (w_print) r_x <= w_last_col ? '0 : r_x + COL_BITS'(1);
            if (in_char == CHR_CR) r_x <= '0;
            if (in_char == CHR_BS && r_x != '0) r_x <= r_x - COL_BITS'(1);
            if (in_char == CHR_FF) begin
              r_state <= CLEAR_ALL;
              r_cnt   <= '0;
            end
          end
          // Bottom-row line feed scrolls: the old top row becomes the new bottom.
          if (w_lf) begin
            if (r_y != '1) begin
              r_y <= r_y + PAGE_BITS'(1);
            end else begin
              r_off     <= r_off + PAGE_BITS'(1);
              r_clr_row <= r_off;
              r_state   <= CLEAR_ROW;
              r_cnt     <= '0;
            end
          end
        end
      endcase
    end
  end

  assign w_rd_row  = in_vpage + r_off;
  assign w_rd_col  = in_hpix[HCTR_BITS-1:TW_BITS];
  assign w_rd_addr = {w_rd_row, w_rd_col};

  ram_2port #(
    .ADDR_BITS (ADDR_BITS),
    .WORD_BITS (8)
  ) u_text_ram (
    .i_clk     (in_clk),
    .i_rst     (in_rst),
    .i_wr_en   (w_we),
    .i_wr_addr (w_waddr),
    .i_wr_data (w_wdata),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) out_font_col <= '0;
    else        out_font_col <= in_hpix[TW_BITS-1:0];
  end

  assign out_font_char  = w_rd_data[6:0];
  assign w_unused       = w_rd_data[7];
  assign out_busy       = (r_state != IDLE);
  assign out_char_ready = (r_state == IDLE);
  assign out_cursor_x   = r_x;
  assign out_cursor_y   = r_y;

`ifdef OLED_TEXTTERM_CURSOR_EN
  localparam int BLK_BITS =
    ($clog2(CURSOR_BLINK_CYCLES) < 1) ? 1 : $clog2(CURSOR_BLINK_CYCLES);

  logic [BLK_BITS-1:0] r_blk;
  logic                r_phase;
  logic                r_hl;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_blk   <= '0;
      r_phase <= 1'b0;
      r_hl    <= 1'b0;
    end else begin
      if (r_blk == BLK_BITS'(CURSOR_BLINK_CYCLES - 1)) begin
        r_blk   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_blk <= r_blk + BLK_BITS'(1);
      end
      r_hl <= r_phase && (w_rd_col == r_x) && (in_vpage == r_y);
    end
  end

  assign out_pixels = r_hl ? ~in_font_line : in_font_line;
`else
  localparam int unused_blink = CURSOR_BLINK_CYCLES;

  assign out_pixels = in_font_line;
`endif

endmodule
